// File: rtl/dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                  |
// | Purpose  : shares the data memory port between the cpu MEM stage and an  |
// |            ext loader/debug requester; fixed-latency access sequencing.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] c_lat_load   = 4'(MEM_LAT - 1);
  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_lat_cnt;
  logic [3:0]        r_starve_cnt;
  logic              r_owner;   // 0 = cpu, 1 = ext
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ext_rdata;
  logic              w_grant;
  logic              w_grant_ext;
  logic              w_capture;

  assign w_grant     = cpu_req | ext_req;
  assign w_grant_ext = ext_req & (~cpu_req | (r_starve_cnt == c_starve_max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    cpu_done     = 1'b0;
    ext_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en = 1'b1;
        mem_we = r_we;
        if (MEM_LAT == 1) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // lat_cnt reaches zero on this edge, which is when mem_rdata is valid
        if (r_lat_cnt == 4'd1) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        cpu_done     = ~r_owner;
        ext_done     = r_owner;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_rdata  <= '0;
      r_ext_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner <= w_grant_ext;
            if (w_grant_ext) begin
              r_we         <= ext_we;
              r_addr       <= ext_addr;
              r_wdata      <= ext_wdata;
              r_starve_cnt <= '0;
            end else begin
              r_we    <= cpu_we;
              r_addr  <= cpu_addr;
              r_wdata <= cpu_wdata;
              if (!ext_req) begin
                r_starve_cnt <= '0;
              end else if (r_starve_cnt != c_starve_max) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
              end
            end
          end
        end
        S_ISSUE: r_lat_cnt <= c_lat_load;
        S_WAIT:  r_lat_cnt <= r_lat_cnt - 4'd1;
        default: ;
      endcase
      if (w_capture && !r_we) begin
        if (r_owner) begin
          r_ext_rdata <= mem_rdata;
        end else begin
          r_cpu_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign ext_rdata = r_ext_rdata;
  assign cpu_stall = cpu_req & ~cpu_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dmem_arbiter                                               |
// | Purpose  : self-checking bench for dmem_arbiter (MEM_LAT=2 and 1 builds) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int          ML    = 2;
  localparam logic [63:0] c_bad = 64'hBAD0_BAD0_BAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [63:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [63:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_stall, ext_done, mem_en, mem_we;
  logic [63:0] mem_ret;

  logic        cpu_req1, cpu_we1;
  logic [63:0] cpu_addr1, cpu_wdata1;
  logic [63:0] cpu_rdata1, ext_rdata1, mem_addr1, mem_wdata1, mem_rdata1, mem_ret1;
  logic        cpu_done1, cpu_stall1, ext_done1, mem_en1, mem_we1;
  logic        ext_req1 = 1'b0, ext_we1 = 1'b0;
  logic [63:0] ext_addr1 = 64'd0, ext_wdata1 = 64'd0;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(ML), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
    .cpu_rdata(cpu_rdata1), .cpu_done(cpu_done1), .cpu_stall(cpu_stall1),
    .ext_req(ext_req1), .ext_we(ext_we1), .ext_addr(ext_addr1), .ext_wdata(ext_wdata1),
    .ext_rdata(ext_rdata1), .ext_done(ext_done1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data is valid only ML-1 cycles after the mem_en cycle.
  logic [3:0] since = 4'd0;
  always @(posedge clk) begin
    if (mem_en) since <= 4'd1;
    else if (since != 4'd0 && since != 4'hF) since <= since + 4'd1;
  end
  assign mem_rdata  = (!mem_en && since == 4'(ML - 1)) ? mem_ret : c_bad;
  assign mem_rdata1 = mem_en1 ? mem_ret1 : c_bad;

  typedef struct {
    logic        owner;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mret;
    logic [63:0] exp_cpu;
    logic [63:0] exp_ext;
  } vec_t;

  typedef struct {
    logic        owner;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } memev_t;

  vec_t   vecs[6];
  exp_t   exp_q[$];
  memev_t mem_q[$];
  memev_t mon_ev;
  int     n_cmp = 0;
  int     n_bad = 0;

  always @(negedge clk) begin
    if (rst_n && mem_en) begin
      mon_ev.cyc   = cyc;
      mon_ev.we    = mem_we;
      mon_ev.addr  = mem_addr;
      mon_ev.wdata = mem_wdata;
      mem_q.push_back(mon_ev);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic own, input logic [63:0] rd, input int c);
    exp_t e;
    e.owner = own;
    e.rdata = rd;
    e.cyc   = c;
    exp_q.push_back(e);
  endtask

  // Waits for the next done pulse and scores it against the head of exp_q.
  task automatic service(input int limit, output int who);
    exp_t e;
    who = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (cpu_done || ext_done) begin
        who = ext_done ? 1 : 0;
        chk("dual_done", 64'(cpu_done & ext_done), 64'd0);
        chk("exp_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("done_owner", 64'(who), 64'(e.owner));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("owner_rdata", (who == 1) ? ext_rdata : cpu_rdata, e.rdata);
        if (who == 0) chk("stall_at_done", 64'(cpu_stall), 64'd0);
        return;
      end else if (cpu_req) begin
        chk("stall_wait", 64'(cpu_stall), 64'd1);
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL done_timeout: got no done pulse in %0d cycles, want one (cycle %0d)", limit, cyc);
  endtask

  task automatic check_mem(input int ecyc, input logic ewe, input logic [63:0] eaddr,
                           input logic [63:0] ewdata);
    memev_t ev;
    chk("mem_en_count", 64'(mem_q.size()), 64'd1);
    if (mem_q.size() == 0) return;
    ev = mem_q.pop_front();
    chk("mem_en_cycle", 64'(ev.cyc), 64'(ecyc));
    chk("mem_we", 64'(ev.we), 64'(ewe));
    chk("mem_addr", ev.addr, eaddr);
    if (ewe) chk("mem_wdata", ev.wdata, ewdata);
    mem_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int who;
    int d;
    int extra;
    vec_t v;

    vecs[0] = '{1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD, 64'hDEAD, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 64'h20, 64'h55, 64'h1234, 64'hDEAD, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 64'h28, 64'h0, 64'hCAFE_F00D, 64'hDEAD, 64'hCAFE_F00D};
    vecs[3] = '{1'b0, 1'b1, 64'h30, 64'hAAAA_5555_AAAA_5555, 64'h9999, 64'hDEAD, 64'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'hFEDC_BA98_7654_3210,
                64'hFEDC_BA98_7654_3210, 64'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF,
                64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};

    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 64'd0; cpu_wdata = 64'd0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 64'd0; ext_wdata = 64'd0;
    cpu_req1 = 1'b0; cpu_we1 = 1'b0; cpu_addr1 = 64'd0; cpu_wdata1 = 64'd0;
    mem_ret = 64'd0; mem_ret1 = 64'd0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_cpu_rdata", cpu_rdata, 64'd0);
    chk("rst_ext_rdata", ext_rdata, 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_cpu_done", 64'(cpu_done), 64'd0);
    chk("rst_ext_done", 64'(ext_done), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);

    // Table-driven single accesses
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      v = vecs[i];
      mem_ret = v.mret;
      if (v.owner) begin
        ext_req = 1'b1; ext_we = v.we; ext_addr = v.addr; ext_wdata = v.wdata;
      end else begin
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      end
      d = cyc;
      push_exp(v.owner, v.owner ? v.exp_ext : v.exp_cpu, d + 1 + ML);
      service(12, who);
      cpu_req = 1'b0;
      ext_req = 1'b0;
      check_mem(d + 1, v.we, v.addr, v.wdata);
      chk("vec_cpu_rdata", cpu_rdata, v.exp_cpu);
      chk("vec_ext_rdata", ext_rdata, v.exp_ext);
    end

    // Both requests held: 4 cpu grants, then 1 ext, repeating
    @(negedge clk); #1;
    mem_ret = 64'h77;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h100;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'h200;
    d = cyc;
    for (int j = 0; j < 10; j++) push_exp((j % 5) == 4, 64'h77, d + 1 + ML + j * (ML + 2));
    for (int j = 0; j < 10; j++) begin
      service(12, who);
      if (j == 9) begin
        cpu_req = 1'b0;
        ext_req = 1'b0;
      end
      check_mem(d + 1 + j * (ML + 2), 1'b0, ((j % 5) == 4) ? 64'h200 : 64'h100, 64'h0);
    end

    // Simultaneous arrival with starve_cnt cleared: cpu first, ext next
    @(negedge clk); #1;
    mem_ret = 64'h1111;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h300;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 64'h400;
    d = cyc;
    push_exp(1'b0, 64'h1111, d + 1 + ML);
    push_exp(1'b1, 64'h2222, d + 1 + ML + ML + 2);
    service(12, who);
    cpu_req = 1'b0;
    mem_ret = 64'h2222;
    check_mem(d + 1, 1'b0, 64'h300, 64'h0);
    service(12, who);
    ext_req = 1'b0;
    check_mem(d + 1 + ML + 2, 1'b0, 64'h400, 64'h0);
    extra = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (cpu_done || ext_done) extra++;
    end
    chk("extra_done", 64'(extra), 64'd0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset asserted while the access is in WAIT
    @(negedge clk); #1;
    mem_ret = 64'h5555;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h500;
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("wrst_mem_en", 64'(mem_en), 64'd0);
    chk("wrst_cpu_done", 64'(cpu_done), 64'd0);
    chk("wrst_cpu_rdata", cpu_rdata, 64'd0);
    chk("wrst_ext_rdata", ext_rdata, 64'd0);
    chk("wrst_mem_addr", mem_addr, 64'd0);
    chk("wrst_mem_wdata", mem_wdata, 64'd0);
    repeat (2) begin
      @(negedge clk); #1;
      chk("wrst_no_done", 64'(cpu_done | ext_done), 64'd0);
    end
    mem_q.delete();
    rst_n = 1'b1;
    d = cyc;
    push_exp(1'b0, 64'h5555, d + 1 + ML);
    service(12, who);
    cpu_req = 1'b0;
    check_mem(d + 1, 1'b0, 64'h500, 64'h0);

    // MEM_LAT=1 build, address changed after grant
    @(negedge clk); #1;
    mem_ret1 = 64'h4141;
    cpu_req1 = 1'b1; cpu_we1 = 1'b0; cpu_addr1 = 64'h40;
    @(negedge clk); #1;
    chk("l1_mem_en", 64'(mem_en1), 64'd1);
    chk("l1_mem_addr", mem_addr1, 64'h40);
    chk("l1_stall_busy", 64'(cpu_stall1), 64'd1);
    chk("l1_early_done", 64'(cpu_done1), 64'd0);
    cpu_addr1 = 64'h999;
    @(negedge clk); #1;
    chk("l1_done", 64'(cpu_done1), 64'd1);
    chk("l1_rdata", cpu_rdata1, 64'h4141);
    chk("l1_stall_done", 64'(cpu_stall1), 64'd0);
    chk("l1_addr_latched", mem_addr1, 64'h40);
    cpu_req1 = 1'b0;
    @(negedge clk); #1;
    chk("l1_done_pulse", 64'(cpu_done1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
